// File: rtl/lfsr_rng_quant_pkg.sv
// Shared types and constants for the LFSR random source and quantiser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lfsr_rng_quant_pkg;

   // On-demand handshake states; ACK is the single cycle that ack is high
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACK      = 2'd1,
      WAIT_LOW = 2'd2
   } fsm_state_t;

   // Ceiling log2, returns 0 for values of 0 or 1
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((longint'(1) << r) < longint'(value)) r = r + 1;
      return r;
   endfunction

   // One-hot mask for polynomial term x^n, which feeds from lfsr[n-1]
   function automatic logic [31:0] term(input int n);
      return 32'd1 << (n - 1);
   endfunction

   // Maximal-length feedback masks for widths 3..32
   function automatic logic [31:0] default_taps(input int width);
      case (width)
         3:  return term(3)  | term(2);
         4:  return term(4)  | term(3);
         5:  return term(5)  | term(3);
         6:  return term(6)  | term(5);
         7:  return term(7)  | term(6);
         8:  return term(8)  | term(6)  | term(5) | term(4);
         9:  return term(9)  | term(5);
         10: return term(10) | term(7);
         11: return term(11) | term(9);
         12: return term(12) | term(6)  | term(4) | term(1);
         13: return term(13) | term(4)  | term(3) | term(1);
         14: return term(14) | term(5)  | term(3) | term(1);
         15: return term(15) | term(14);
         16: return term(16) | term(15) | term(13) | term(4);
         17: return term(17) | term(14);
         18: return term(18) | term(11);
         19: return term(19) | term(6)  | term(2) | term(1);
         20: return term(20) | term(17);
         21: return term(21) | term(19);
         22: return term(22) | term(21);
         23: return term(23) | term(18);
         24: return term(24) | term(23) | term(22) | term(17);
         25: return term(25) | term(22);
         26: return term(26) | term(6)  | term(2) | term(1);
         27: return term(27) | term(5)  | term(2) | term(1);
         28: return term(28) | term(25);
         29: return term(29) | term(27);
         30: return term(30) | term(6)  | term(4) | term(1);
         31: return term(31) | term(28);
         32: return term(32) | term(22) | term(2) | term(1);
         default: return 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/lfsr_rng_quant_lfsr_core.sv
// Fibonacci LFSR step datapath with seed load and all-zero guard.
// Latency: lfsr updates one cycle after load/step; lfsr_next is combinational.
// Backpressure: none; steps only when told to, load wins over step.
module lfsr_core #(
   parameter int              WIDTH = 10,
   parameter logic [WIDTH-1:0] TAPS = 10'h240
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] lfsr,
   output logic [WIDTH-1:0] lfsr_next,
   output logic [WIDTH-1:0] load_val
);

   // A zero seed would lock the register, so it is promoted to 1
   assign load_val = (seed == '0) ? WIDTH'(1) : seed;

   // Next value: shift left, XOR of tapped bits enters at bit 0; escape from zero
   always_comb begin
      lfsr_next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
      if (lfsr == '0) lfsr_next = WIDTH'(1);
   end

   // State register: reset to 1, load has priority over step
   always_ff @(posedge clk) begin
      if (reset)     lfsr <= WIDTH'(1);
      else if (load) lfsr <= load_val;
      else if (step) lfsr <= lfsr_next;
   end

endmodule

// File: rtl/lfsr_rng_quant.sv
// LFSR random source stepped by a tick divider or a req/ack handshake, with bucket quantiser.
// Latency: rnd/bin/valid appear one cycle after the step decision; ack coincides with valid.
// Backpressure: req is level-held; one step per req assertion, req must drop before the next.
module lfsr_rng_quant
   import lfsr_rng_quant_pkg::*;
#(
   parameter int               WIDTH    = 10,
   parameter logic [WIDTH-1:0] TAPS     = 10'h240,
   parameter int               TICK_DIV = 50_000_000,
   parameter int               BIN_BITS = 2,
   parameter int               SEQ_LEN  = 15
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        mode,
   input  logic                        seed_load,
   input  logic [WIDTH-1:0]            seed,
   input  logic                        req,
   output logic                        ack,
   output logic [WIDTH-1:0]            rnd,
   output logic [BIN_BITS-1:0]         bin,
   output logic                        valid,
   output logic [clog2(SEQ_LEN)-1:0]   sample_cnt,
   output logic                        wrap
);

   localparam int CNT_W  = clog2(SEQ_LEN);
   localparam int TICK_W = (TICK_DIV > 1) ? clog2(TICK_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SEQ_LEN - 1);

   logic [TICK_W-1:0] tick_cnt;
   logic              tick;
   logic              step;
   fsm_state_t        state_q;
   fsm_state_t        state_d;
   logic [WIDTH-1:0]  lfsr_next;
   logic [WIDTH-1:0]  load_val;

   assign tick = (tick_cnt == TICK_LAST);

   // Free-running divider; only reset and seed_load restart it, mode never does
   always_ff @(posedge clk) begin
      if (reset || seed_load) tick_cnt <= '0;
      else if (tick)          tick_cnt <= '0;
      else                    tick_cnt <= tick_cnt + TICK_W'(1);
   end

   // Handshake state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Step decision and handshake next-state; seed_load drops any step and parks in IDLE
   always_comb begin
      state_d = state_q;
      step    = 1'b0;
      ack     = (state_q == ACK);
      if (!mode) begin
         step    = tick;
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (req) begin
                  step    = 1'b1;
                  state_d = ACK;
               end
            end
            ACK:      state_d = WAIT_LOW;
            WAIT_LOW: if (!req) state_d = IDLE;
            default:  state_d = IDLE;
         endcase
      end
      if (seed_load) begin
         step    = 1'b0;
         state_d = IDLE;
      end
   end

   lfsr_core #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
   ) u_core (
      .clk       (clk),
      .reset     (reset),
      .load      (seed_load),
      .step      (step),
      .seed      (seed),
      .lfsr      (rnd),
      .lfsr_next (lfsr_next),
      .load_val  (load_val)
   );

   // Quantised bucket, step strobes and modulo sample counter
   always_ff @(posedge clk) begin
      if (reset) begin
         bin        <= '0;
         valid      <= 1'b0;
         wrap       <= 1'b0;
         sample_cnt <= '0;
      end else if (seed_load) begin
         bin        <= load_val[WIDTH-1 -: BIN_BITS];
         valid      <= 1'b0;
         wrap       <= 1'b0;
         sample_cnt <= '0;
      end else begin
         valid <= step;
         wrap  <= step && (sample_cnt == CNT_LAST);
         if (step) begin
            bin        <= lfsr_next[WIDTH-1 -: BIN_BITS];
            sample_cnt <= (sample_cnt == CNT_LAST) ? '0 : sample_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_lfsr_rng_quant.sv
// Self-checking bench for lfsr_rng_quant against a transaction-level reference model.
// Latency: expects valid one cycle after each step decision, every TICK_DIV cycles in free-run.
// Backpressure: drives req as a level held until ack, then low for a random gap.
module tb_lfsr_rng_quant;

   localparam int         W    = 10;
   localparam logic [9:0] TAPS_TB = 10'h240;
   localparam int         SEQ  = 15;
   localparam int         TDIV = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       mode;
   logic       seed_load;
   logic [9:0] seed;
   logic       req;
   logic       ack;
   logic [9:0] rnd;
   logic [1:0] bin;
   logic       valid;
   logic [3:0] sample_cnt;
   logic       wrap;

   int n_checks = 0;
   int n_err    = 0;
   int m_lfsr;
   int m_cnt;

   lfsr_rng_quant #(
      .WIDTH    (W),
      .TAPS     (TAPS_TB),
      .TICK_DIV (TDIV),
      .BIN_BITS (2),
      .SEQ_LEN  (SEQ)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .mode       (mode),
      .seed_load  (seed_load),
      .seed       (seed),
      .req        (req),
      .ack        (ack),
      .rnd        (rnd),
      .bin        (bin),
      .valid      (valid),
      .sample_cnt (sample_cnt),
      .wrap       (wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Polynomial step from parity of tapped bits, computed arithmetically
   function automatic int ref_next(input int x);
      int ones;
      ones = 0;
      if (x == 0) return 1;
      for (int i = 0; i < W; i++)
         if (TAPS_TB[i] && ((x >> i) % 2 == 1)) ones++;
      return ((x * 2) % 1024) + (ones % 2);
   endfunction

   task automatic cyc();
      @(negedge clk);
   endtask

   // Advance the model by one step and compare every output of the valid cycle
   task automatic on_valid(input string tag);
      m_lfsr = ref_next(m_lfsr);
      m_cnt  = (m_cnt + 1) % SEQ;
      check({tag, "_rnd"},  rnd, m_lfsr);
      check({tag, "_bin"},  bin, m_lfsr / 256);
      check({tag, "_cnt"},  sample_cnt, m_cnt);
      check({tag, "_wrap"}, wrap, (m_cnt == 0));
      check({tag, "_ack"},  ack, mode);
   endtask

   task automatic wait_valid(input int budget, output int waited, output bit got);
      got = 0;
      waited = 0;
      for (int k = 0; k < budget; k++) begin
         cyc();
         waited++;
         if (valid) begin
            got = 1;
            break;
         end
      end
      if (!got) check("valid_seen", valid, 1);
   endtask

   task automatic load(input logic [9:0] s);
      seed_load = 1'b1;
      seed = s;
      cyc();
      seed_load = 1'b0;
      m_lfsr = (s == 0) ? 1 : int'(s);
      m_cnt = 0;
      check("load_rnd",   rnd, m_lfsr);
      check("load_bin",   bin, m_lfsr / 256);
      check("load_cnt",   sample_cnt, 0);
      check("load_valid", valid, 0);
   endtask

   // One on-demand request: hold until ack, linger, then drop for a gap
   task automatic pulse(input string tag);
      int w;
      bit got;
      int extra;
      extra = 0;
      req = 1'b1;
      wait_valid(4, w, got);
      if (got) on_valid(tag);
      repeat ($urandom_range(0, 4)) begin
         cyc();
         extra += valid;
      end
      req = 1'b0;
      repeat ($urandom_range(3, 6)) begin
         cyc();
         extra += valid;
      end
      check({tag, "_extra_valid"}, extra, 0);
   endtask

   initial begin
      int w;
      bit got;
      int nv;
      int na;
      int exp41 [4] = '{26, 52, 104, 209};

      reset = 1'b1; mode = 1'b0; seed_load = 1'b0; seed = '0; req = 1'b0;
      cyc(); cyc();
      check("rst_rnd",   rnd, 1);
      check("rst_bin",   bin, 0);
      check("rst_cnt",   sample_cnt, 0);
      check("rst_ack",   ack, 0);
      check("rst_valid", valid, 0);
      check("rst_wrap",  wrap, 0);
      reset = 1'b0;

      // Free-run from seed 13
      mode = 1'b0;
      load(10'd13);
      for (int i = 0; i < 4; i++) begin
         wait_valid(8, w, got);
         check("fr13_interval", w, TDIV);
         if (got) begin
            on_valid("fr13");
            check("fr13_const", rnd, exp41[i]);
         end
      end

      // Zero seed loaded in a tick cycle: step dropped, divider restarted
      cyc(); cyc(); cyc();
      load(10'd0);
      wait_valid(8, w, got);
      check("zseed_interval", w, TDIV);
      if (got) begin
         on_valid("zseed");
         check("zseed_rnd2", rnd, 2);
      end

      // Full period from seed 1
      load(10'd1);
      for (int i = 1; i <= 1023; i++) begin
         wait_valid(8, w, got);
         if (!got) break;
         on_valid("period");
         check("period_nonzero", (rnd != 0), 1);
         check("period_one", (rnd == 1), (i == 1023));
      end

      // Random seeds in free-run
      repeat (4) begin
         load(10'($urandom_range(0, 1023)));
         repeat (20) begin
            wait_valid(8, w, got);
            if (!got) break;
            on_valid("rseed");
         end
      end

      // On-demand: req held 20 cycles yields exactly one step
      mode = 1'b1;
      load(10'd13);
      req = 1'b1;
      nv = 0; na = 0;
      for (int k = 0; k < 20; k++) begin
         cyc();
         nv += valid;
         na += ack;
         if (valid) on_valid("hold");
      end
      check("hold_nvalid", nv, 1);
      check("hold_nack",   na, 1);
      check("hold_rnd",    rnd, 26);
      req = 1'b0;
      cyc(); cyc(); cyc();
      req = 1'b1;
      wait_valid(4, w, got);
      if (got) on_valid("req2");
      check("req2_rnd", rnd, 52);
      req = 1'b0;
      cyc(); cyc(); cyc();

      // Random request pulses
      repeat (30) pulse("rpulse");

      // Reset in WAIT_LOW with sample_cnt at 7
      load(10'd13);
      repeat (6) pulse("pre_rst");
      req = 1'b1;
      wait_valid(4, w, got);
      if (got) on_valid("pre_rst7");
      check("pre_rst_cnt7", sample_cnt, 7);
      cyc();
      reset = 1'b1;
      cyc();
      check("midrst_rnd",   rnd, 1);
      check("midrst_cnt",   sample_cnt, 0);
      check("midrst_ack",   ack, 0);
      check("midrst_valid", valid, 0);
      check("midrst_bin",   bin, 0);
      m_lfsr = 1; m_cnt = 0;
      reset = 1'b0;
      req = 1'b0;
      cyc();
      req = 1'b1;
      wait_valid(4, w, got);
      if (got) on_valid("post_rst");
      check("post_rst_rnd", rnd, 2);
      req = 1'b0;
      cyc(); cyc(); cyc();

      // Top bucket: seed all ones
      load(10'h3FF);
      check("top_load_bin", bin, 3);
      req = 1'b1;
      wait_valid(4, w, got);
      if (got) on_valid("top");
      check("top_rnd", rnd, 10'h3FE);
      check("top_bin", bin, 3);
      req = 1'b0;
      cyc();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/lfsr_rng_quant.md
LFSR_RNG_QUANT -- requirements
Module: lfsr_rng_quant

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10: LFSR and rnd width, legal range 3..32.
REQ-002 The block SHALL have parameter TAPS, default 10'h240: feedback mask where bit i set means lfsr[i] enters the XOR (default gives x^10+x^7+1).
REQ-003 The block SHALL have parameter TICK_DIV, default 50_000_000: clk cycles per free-run step, minimum 1.
REQ-004 The block SHALL have parameter BIN_BITS, default 2: quantiser output width, 1..WIDTH.
REQ-005 The block SHALL have parameter SEQ_LEN, default 15: sample-counter modulus, minimum 2.
REQ-006 The block SHALL have port clk, input, 1 bit: clock.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port mode, input, 1 bit: 0 = free-run on tick, 1 = on-demand via req.
REQ-009 The block SHALL have port seed_load, input, 1 bit: load seed this cycle.
REQ-010 The block SHALL have port seed, input, WIDTH bits: seed value.
REQ-011 The block SHALL have port req, input, 1 bit: on-demand step request, level-held until ack.
REQ-012 The block SHALL have port ack, output, 1 bit: one-cycle pulse acknowledging req.
REQ-013 The block SHALL have port rnd, output, WIDTH bits: current random value.
REQ-014 The block SHALL have port bin, output, BIN_BITS bits: quantised bucket of rnd.
REQ-015 The block SHALL have port valid, output, 1 bit: one-cycle pulse when rnd/bin update from a step.
REQ-016 The block SHALL have port sample_cnt, output, clog2(SEQ_LEN) bits: steps taken modulo SEQ_LEN.
REQ-017 The block SHALL have port wrap, output, 1 bit: one-cycle pulse with the valid that returns sample_cnt to 0.

Function
REQ-018 The tick counter SHALL count 0..TICK_DIV-1 every cycle. It SHALL assert an internal tick on the terminal value and return to 0 on the next cycle.
REQ-019 In mode 0 a step SHALL occur on each tick, and req SHALL be ignored (ack stays 0).
REQ-020 In mode 1 ticks SHALL be ignored.
REQ-021 In mode 1 the FSM SHALL have states IDLE, ACK and WAIT_LOW.
REQ-022 In IDLE with req=1, the FSM SHALL step, pulse ack and valid in the following cycle, and enter WAIT_LOW.
REQ-023 In WAIT_LOW the FSM SHALL return to IDLE when req=0, so one step is taken per req assertion.
REQ-024 A step SHALL compute fb = XOR-reduce(lfsr & TAPS) and lfsr_next = {lfsr[WIDTH-2:0], fb}.
REQ-025 Each step SHALL register rnd = lfsr_next and bin = lfsr_next[WIDTH-1 -: BIN_BITS], i.e. equal-width buckets by top bits.
REQ-026 valid SHALL pulse one cycle after each step decision, together with the updated rnd/bin.
REQ-027 sample_cnt SHALL increment per step, wrap from SEQ_LEN-1 to 0, and pulse wrap on that wrap.
REQ-028 seed_load SHALL take priority over a step in the same cycle.
REQ-029 seed_load SHALL set lfsr = rnd = seed, set bin from seed, clear sample_cnt and the tick counter, and return the FSM to IDLE (ack not asserted).
REQ-030 seed_load SHALL NOT assert valid, and SHALL drop any step coincident with it.
REQ-031 A zero seed SHALL be replaced by 1 to prevent all-zero lock-up.
REQ-032 If lfsr is ever 0 at a step, lfsr_next SHALL be 1.
REQ-033 A mode change SHALL take effect the next cycle.
REQ-034 On entering mode 0, the FSM SHALL be forced to IDLE.
REQ-035 A mode change SHALL NOT clear the tick counter.

Reset
REQ-036 On reset: lfsr = 1, rnd = 1, bin = 0, sample_cnt = 0, tick counter = 0, FSM = IDLE, ack = valid = wrap = 0.
REQ-037 Reset SHALL override seed_load, req and tick.
REQ-038 A reset asserted mid-handshake SHALL abort it with no ack.

Structure
REQ-039 A shared package SHALL hold the FSM state typedef, default TAPS constants for widths 3..32 (maximal-length), and a clog2 helper.
REQ-040 The block SHALL contain one sub-module, lfsr_core: the WIDTH/TAPS step datapath with load and zero-guard; tick divider and FSM stay in the top.

Verification (WIDTH=10, TAPS=10'h240, BIN_BITS=2, SEQ_LEN=15, TICK_DIV=4)
REQ-041 Mode 0, seed_load seed=13, then free-run -> valid every 4 cycles; rnd = 26, 52, 104, 209; bin = 0, 0, 0, 0.
REQ-042 Mode 0, 1023 steps from seed 1 -> rnd returns to 1 exactly at step 1023, never 0; wrap pulses every 15 valids.
REQ-043 Mode 1, req held high 20 cycles from seed 13 -> exactly one ack and valid, rnd=26. After req low then high again -> rnd=52.
REQ-044 seed_load=1 with seed=0 in the same cycle as a tick -> rnd=1, no valid, sample_cnt=0.
REQ-045 Reset asserted in WAIT_LOW with sample_cnt=7 -> next cycle rnd=1, sample_cnt=0, ack=valid=0, FSM IDLE.
REQ-046 seed=10'h3FF (bin=3), mode 1 single req -> rnd=10'h3FE, bin=3; sweep checks bin matches rnd[9:8] on every valid.
